// File: rtl/barrett_rr_arbiter.sv
// barrett_rr_arbiter: two-way round-robin front end for a fixed-latency barrett reducer with tagged response routing
module barrett_rr_arbiter #(
    parameter int data_size = 32,
    parameter int LATENCY   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_0,
    input  logic                   req_valid_1,
    input  logic [data_size-1:0]   req_data_0,
    input  logic [data_size-1:0]   req_data_1,
    output logic                   req_ready_0,
    output logic                   req_ready_1,
    input  logic                   drain,
    output logic [data_size-1:0]   red_x,
    output logic                   red_valid,
    input  logic [data_size/2-1:0] red_result,
    output logic                   rsp_valid_0,
    output logic                   rsp_valid_1,
    output logic [data_size/2-1:0] rsp_data,
    output logic                   idle,
    output logic [15:0]            issued_count
);
    logic               last_grant;
    logic               red_id;
    logic               acc;
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_id;
    logic               tv;
    logic               tid;
    always_comb begin
        req_ready_0 = !rst && !drain && req_valid_0 && (!req_valid_1 || last_grant);
        req_ready_1 = !rst && !drain && req_valid_1 && (!req_valid_0 || !last_grant);
        acc         = req_ready_0 || req_ready_1;
        tv          = tag_v[LATENCY-1];
        tid         = tag_id[LATENCY-1];
        idle        = !red_valid && !(|tag_v) && !rsp_valid_0 && !rsp_valid_1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            red_valid    <= 1'b0;
            red_id       <= 1'b0;
            red_x        <= '0;
            tag_v        <= '0;
            tag_id       <= '0;
            rsp_valid_0  <= 1'b0;
            rsp_valid_1  <= 1'b0;
            rsp_data     <= '0;
            issued_count <= '0;
        end else begin
            last_grant   <= acc ? req_ready_1 : last_grant;
            red_valid    <= acc;
            red_id       <= acc ? req_ready_1 : red_id;
            red_x        <= acc ? (req_ready_1 ? req_data_1 : req_data_0) : red_x;
            // tag enters alongside red_valid so it leaves when red_result is valid
            tag_v        <= LATENCY'({tag_v, red_valid});
            tag_id       <= LATENCY'({tag_id, red_id});
            rsp_valid_0  <= tv && !tid;
            rsp_valid_1  <= tv && tid;
            rsp_data     <= tv ? red_result : rsp_data;
            issued_count <= issued_count + 16'(acc);
        end
    end
endmodule

// File: tb/tb_barrett_rr_arbiter.sv
// tb_barrett_rr_arbiter: directed table and sequence checks with a mod-2971 reducer model and response scoreboard
module tb_barrett_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic [31:0] req_data_0 = '0, req_data_1 = '0;
    logic        req_ready_0, req_ready_1;
    logic        drain = 1'b0;
    logic [31:0] red_x;
    logic        red_valid;
    logic [15:0] red_result = '0;
    logic        rsp_valid_0, rsp_valid_1;
    logic [15:0] rsp_data;
    logic        idle;
    logic [15:0] issued_count;

    barrett_rr_arbiter #(.data_size(32), .LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_data_0(req_data_0), .req_data_1(req_data_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .drain(drain), .red_x(red_x), .red_valid(red_valid), .red_result(red_result),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1), .rsp_data(rsp_data),
        .idle(idle), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    // reducer model: one register stage computing X mod 2971
    always_ff @(posedge clk) red_result <= 16'(red_x % 2971);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_seen = 0;

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        v0;
        logic        v1;
        logic        dr;
        logic        e0;
        logic        e1;
        logic [15:0] ecnt;
    } vec_t;
    vec_t rows[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid_0 && rsp_valid_1) chk("rsp_both", 1, 0);
        if (rsp_valid_0 || rsp_valid_1) begin
            rsp_seen++;
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("rsp_id", {31'd0, rsp_valid_1}, {31'd0, e.id});
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                chk("rsp_latency", cyc, e.cyc + 3);
            end
        end
        if (rst) sb.delete();
        if (req_valid_0 && req_ready_0) sb.push_back('{1'b0, 16'(req_data_0 % 2971), cyc});
        if (req_valid_1 && req_ready_1) sb.push_back('{1'b1, 16'(req_data_1 % 2971), cyc});
    end

    task automatic cyc_set(input logic v0, input logic v1, input logic [31:0] d0,
                           input logic [31:0] d1, input logic dr);
        @(posedge clk);
        #1;
        req_valid_0 = v0;
        req_valid_1 = v1;
        req_data_0  = d0;
        req_data_1  = d1;
        drain       = dr;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b1;
        drain = 1'b0;
        #1;
        chk("rst_ready_0", {31'd0, req_ready_0}, 0);
        chk("rst_ready_1", {31'd0, req_ready_1}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        #1;
        chk("rst_red_valid", {31'd0, red_valid}, 0);
        chk("rst_red_x", red_x, 0);
        chk("rst_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 0);
        chk("rst_idle", {31'd0, idle}, 1);
        chk("rst_count", {16'd0, issued_count}, 0);
    endtask

    initial begin
        int base;
        rows = '{
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd6},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd7}
        };
        do_reset();

        // round-robin table from a fresh pointer
        for (int i = 0; i < 10; i++) begin
            cyc_set(rows[i].v0, rows[i].v1, 32'(i * 100 + 1), 32'(i * 100 + 2), rows[i].dr);
            chk($sformatf("tbl%0d_ready_0", i), {31'd0, req_ready_0}, {31'd0, rows[i].e0});
            chk($sformatf("tbl%0d_ready_1", i), {31'd0, req_ready_1}, {31'd0, rows[i].e1});
            chk($sformatf("tbl%0d_count", i), {16'd0, issued_count}, {16'd0, rows[i].ecnt});
        end
        repeat (5) cyc_set(0, 0, 0, 0, 0);
        chk("tbl_idle", {31'd0, idle}, 1);

        // single operand timing
        do_reset();
        cyc_set(1, 0, 27311837, 0, 0);
        chk("single_ready", {31'd0, req_ready_0}, 1);
        cyc_set(0, 0, 0, 0, 0);
        chk("single_red_valid", {31'd0, red_valid}, 1);
        chk("single_red_x", red_x, 27311837);
        chk("single_t1_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        cyc_set(0, 0, 0, 0, 0);
        chk("single_t2_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        cyc_set(0, 0, 0, 0, 0);
        chk("single_t3_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 1);
        chk("single_t3_data", {16'd0, rsp_data}, 2405);
        cyc_set(0, 0, 0, 0, 0);
        chk("single_t4_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        chk("single_t4_idle", {31'd0, idle}, 1);

        // contention: strict alternation starting with requester 0
        do_reset();
        base = rsp_seen;
        for (int i = 0; i < 8; i++) begin
            cyc_set(1, 1, 5942, 2970, 0);
            chk($sformatf("cont%0d_ready_0", i), {31'd0, req_ready_0}, {31'd0, (i % 2) == 0});
            chk($sformatf("cont%0d_ready_1", i), {31'd0, req_ready_1}, {31'd0, (i % 2) == 1});
        end
        repeat (5) cyc_set(0, 0, 0, 0, 0);
        chk("cont_rsp_count", rsp_seen - base, 8);

        // drain with two operands in flight
        do_reset();
        base = rsp_seen;
        cyc_set(0, 1, 0, 11111, 0);
        chk("drain_acc0", {31'd0, req_ready_1}, 1);
        cyc_set(0, 1, 0, 22222, 0);
        chk("drain_acc1", {31'd0, req_ready_1}, 1);
        for (int k = 0; k < 5; k++) begin
            cyc_set(0, 1, 0, 33333, 1);
            chk($sformatf("drain%0d_ready", k), {30'd0, req_ready_1, req_ready_0}, 0);
            if (k == 1 || k == 2) chk($sformatf("drain%0d_rsp", k), {31'd0, rsp_valid_1}, 1);
            if (k == 2) chk("drain_busy", {31'd0, idle}, 0);
            if (k == 3) chk("drain_idle", {31'd0, idle}, 1);
        end
        chk("drain_rsp_count", rsp_seen - base, 2);
        chk("drain_count", {16'd0, issued_count}, 2);
        cyc_set(0, 0, 0, 0, 0);

        // reset while three operands are in flight
        do_reset();
        cyc_set(1, 0, 100, 0, 0);
        cyc_set(1, 0, 200, 0, 0);
        cyc_set(1, 0, 300, 0, 0);
        @(posedge clk);
        #1;
        req_valid_0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        base = rsp_seen;
        chk("mid_count", {16'd0, issued_count}, 0);
        chk("mid_idle", {31'd0, idle}, 1);
        for (int k = 0; k < 5; k++) begin
            cyc_set(0, 0, 0, 0, 0);
            chk($sformatf("mid%0d_rsp", k), {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        end
        chk("mid_rsp_count", rsp_seen - base, 0);

        // counter wrap with continuous single-requester traffic
        do_reset();
        base = rsp_seen;
        for (int i = 0; i < 65537; i++) cyc_set(1, 0, 32'(i * 7919), 0, 0);
        repeat (5) cyc_set(0, 0, 0, 0, 0);
        chk("wrap_count", {16'd0, issued_count}, 1);
        chk("wrap_rsp_count", rsp_seen - base, 65537);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
